prbs_gen_chk: RTL
=================

// Module: prbs_gen_chk
// PURPOSE
//  Parametrised PRBS generator and self-synchronising checker for link/pad BIST.
//  - Generator emits DATA_W bits per clock from a runtime-selectable PRBS7/15/23/31 polynomial.
//  - Checker locks to an incoming PRBS word stream and counts bit errors.
//  - Sits between the core and the IO pins; the top level ties gen_data to uo_out and chk_data to ui_in.
// PARAMETERS
//  DATA_W     8   bits per word, 1..32; gen_data[DATA_W-1] is the oldest (first serial) bit
//  ERR_CNT_W  16  width of the saturating bit-error counter
//  LOCK_CNT   16  consecutive error-free words required to declare lock
//  LOSS_THR   4   consecutive errored words while locked that force relock
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          reset: synchronous, active-HIGH (1 = reset), despite the name
//  en         in   1          generator advance enable, one word per cycle while high
//  poly_sel   in   2          0=PRBS7 x^7+x^6+1, 1=PRBS15 x^15+x^14+1, 2=PRBS23 x^23+x^18+1, 3=PRBS31 x^31+x^28+1
//  inj_err    in   1          request a single-bit error in the next generated word
//  gen_data   out  DATA_W     generated word
//  gen_valid  out  1          gen_data holds a new word this cycle
//  chk_data   in   DATA_W     received word, same bit order as gen_data
//  chk_valid  in   1          chk_data is valid this cycle
//  clr_cnt    in   1          synchronous clear of err_count
//  locked     out  1          checker is in LOCKED
//  err_flag   out  1          one-cycle pulse: the last checked word mismatched while LOCKED
//  err_count  out  ERR_CNT_W  total mismatched bits while LOCKED, saturating
// BEHAVIOUR
//  LFSR is Fibonacci with N = 7/15/23/31; only s[N-1:0] is used.
//  - Per serial step: out = s[N-1]; s <= {s[N-2:0], s[N-1]^s[T-1]}, where T = 6/14/18/28.
//  - One word = DATA_W serial steps computed combinationally in one cycle.
//  Reset:
//  - Generator state = 1, gen_data = 0, gen_valid = 0, pending inj_err cleared.
//  - Checker returns to HUNT; locked = 0, err_flag = 0, err_count = 0.
//  - Reset mid-operation aborts any lock or seeding in progress; it has priority over all inputs.
//  Generator:
//  - en=1: gen_data <= next word, LFSR advances, gen_valid <= 1 (latency 1 cycle).
//  - en=0: gen_data holds, gen_valid <= 0.
//  - inj_err sets a pending flag. The next word generated with en=1 has bit 0 inverted, then the flag clears.
//  - LFSR state is never corrupted by injection. inj_err with en=1 in the same cycle applies to that word.
//  poly_sel change (registered compare with the previous value):
//  - Generator reloads seed 1 on the next cycle.
//  - Checker goes to HUNT, dropping locked.
//  - poly_sel is quasi-static; no other guarantee applies during the change cycle.
//  Checker FSM (advances only on chk_valid=1 cycles; outputs registered, latency 1 cycle):
//  - HUNT: shift chk_data into checker state (last N received bits). After S = ceil(N/DATA_W) words:
//    - seeded s[N-1:0] == 0: stay in HUNT (an all-zero stream must never lock);
//    - otherwise go to VERIFY.
//  - VERIFY: compare chk_data with the word predicted from the checker's own LFSR.
//    - Match: increment the good counter; when it reaches LOCK_CNT go to LOCKED, locked <= 1.
//    - Any mismatch: back to HUNT, counters cleared.
//  - LOCKED: predict from the checker's own LFSR (received errors do not propagate).
//    - Mismatch: err_flag pulses; err_count += popcount(chk_data ^ predicted), saturating at 2^ERR_CNT_W-1.
//    - LOSS_THR consecutive mismatched words: HUNT, locked <= 0.
//    - Any clean word resets the loss counter.
//  err_count:
//  - Bit errors are counted only in LOCKED.
//  - clr_cnt clears it; clr_cnt together with an error in the same cycle leaves the count at 0.
//  - chk_valid=0: FSM, counters and err_flag idle (err_flag <= 0).
// TESTING
//  1. Reset, poly_sel=0, en=1 for 127 cycles (DATA_W=8):
//     - first gen_data = 0x02, gen_valid high 1 cycle after en;
//     - bit stream repeats with period 127.
//  2. PRBS31 loopback gen_data->chk_data, gen_valid->chk_valid:
//     - locked rises after 4 seed + 16 verify words;
//     - err_count = 0 after 1000 words.
//  3. Locked, single inj_err pulse: err_flag exactly one 1-cycle pulse, err_count = 1, locked stays 1.
//  4. Locked, invert 4 consecutive received words:
//     - locked falls after the 4th errored word;
//     - lock regained 20 clean words later.
//  5. ERR_CNT_W=4, locked, invert every received word for 3 words (24 bit errors, LOSS_THR not reached):
//     - err_count saturates at 15;
//     - clr_cnt returns it to 0.
//  6. chk_data tied to 0x00 with chk_valid=1 for 500 cycles: locked never rises.
//  7. Locked at PRBS31, switch poly_sel to 1:
//     - lock drops, generator restarts from seed;
//     - relock within 2 seed + 16 words.
//  8. Assert rst_n mid-VERIFY: all outputs are at reset values the cycle after.

Source files
------------

// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 word generator and self-synchronising checker for link/pad BIST.
// Both sides run a Fibonacci LFSR advanced DATA_W serial steps per clock; MSB of a word is the first bit.
module prbs_gen_chk #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 16,
  parameter int unsigned LOCK_CNT  = 16,
  parameter int unsigned LOSS_THR  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           poly_sel,
  input  logic                 inj_err,
  output logic [DATA_W-1:0]    gen_data,
  output logic                 gen_valid,
  input  logic [DATA_W-1:0]    chk_data,
  input  logic                 chk_valid,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned LW     = 31;
  localparam int unsigned SEED_W = 6;
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned LOSS_W = $clog2(LOSS_THR + 1);
  localparam int unsigned POP_W  = 6;
  localparam int unsigned SUM_W  = ERR_CNT_W + POP_W;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} chk_state_e;

  function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s, input logic [1:0] sel);
    logic [LW-1:0] r;
    r = '0;
    case (sel)
      2'd0:    r = {24'd0, s[5:0],  s[6]  ^ s[5]};
      2'd1:    r = {16'd0, s[13:0], s[14] ^ s[13]};
      2'd2:    r = {8'd0,  s[21:0], s[22] ^ s[17]};
      default: r = {s[29:0], s[30] ^ s[27]};
    endcase
    return r;
  endfunction

  function automatic logic lfsr_msb(input logic [LW-1:0] s, input logic [1:0] sel);
    logic b;
    b = 1'b0;
    case (sel)
      2'd0:    b = s[6];
      2'd1:    b = s[14];
      2'd2:    b = s[22];
      default: b = s[30];
    endcase
    return b;
  endfunction

  function automatic logic [LW-1:0] poly_mask(input logic [1:0] sel);
    logic [LW-1:0] m;
    m = '0;
    case (sel)
      2'd0:    m = 31'h0000_007F;
      2'd1:    m = 31'h0000_7FFF;
      2'd2:    m = 31'h007F_FFFF;
      default: m = 31'h7FFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic [SEED_W-1:0] seed_words(input logic [1:0] sel);
    int unsigned n;
    n = 31;
    case (sel)
      2'd0:    n = 7;
      2'd1:    n = 15;
      2'd2:    n = 23;
      default: n = 31;
    endcase
    return SEED_W'((n + DATA_W - 1) / DATA_W);
  endfunction

  logic [1:0]           poly_q;
  logic                 poly_chg_c;
  logic [LW-1:0]        gen_q, gen_d, gen_s;
  logic [DATA_W-1:0]    gdata_q, gdata_d, gen_word;
  logic                 gvalid_q, gvalid_d;
  logic                 inj_q, inj_d;

  chk_state_e           state_q, state_d;
  logic [LW-1:0]        chk_q, chk_d, pred_s, seed_s;
  logic [DATA_W-1:0]    pred_word, seed_in, diff, diff_sh;
  logic [POP_W-1:0]     pop;
  logic [SUM_W-1:0]     err_sum;
  logic [SEED_W-1:0]    seed_q, seed_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic [LOSS_W-1:0]    loss_q, loss_d;
  logic                 locked_q, locked_d;
  logic                 flag_q, flag_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  assign poly_chg_c = (poly_sel != poly_q);

  // Generator: one word per enabled cycle; injection flips bit 0 of the output only.
  always_comb begin
    gen_d    = gen_q;
    gdata_d  = gdata_q;
    gvalid_d = 1'b0;
    inj_d    = inj_q | inj_err;
    gen_s    = gen_q;
    gen_word = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      gen_word = (gen_word << 1) | DATA_W'(lfsr_msb(gen_s, poly_sel));
      gen_s    = lfsr_step(gen_s, poly_sel);
    end
    if (poly_chg_c) begin
      gen_d = LW'(1);
    end else if (en) begin
      gen_d    = gen_s;
      gdata_d  = gen_word ^ DATA_W'(inj_q | inj_err);
      gvalid_d = 1'b1;
      inj_d    = 1'b0;
    end
  end

  // Checker datapath: the state holds the last N bits, so each prediction is the feedback bit.
  always_comb begin
    pred_s    = chk_q;
    pred_word = '0;
    seed_s    = chk_q;
    seed_in   = chk_data;
    for (int i = 0; i < int'(DATA_W); i++) begin
      pred_s    = lfsr_step(pred_s, poly_sel);
      pred_word = (pred_word << 1) | DATA_W'(pred_s[0]);
      seed_s    = (seed_s << 1) | LW'(seed_in[DATA_W-1]);
      seed_in   = seed_in << 1;
    end
    seed_s  = seed_s & poly_mask(poly_sel);
    diff    = chk_data ^ pred_word;
    diff_sh = diff;
    pop     = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      pop     = pop + POP_W'(diff_sh[0]);
      diff_sh = diff_sh >> 1;
    end
    err_sum = SUM_W'(err_q) + SUM_W'(pop);
  end

  // Checker FSM next state and registered outputs.
  always_comb begin
    state_d  = state_q;
    chk_d    = chk_q;
    seed_d   = seed_q;
    good_d   = good_q;
    loss_d   = loss_q;
    locked_d = locked_q;
    flag_d   = 1'b0;
    err_d    = err_q;
    if (poly_chg_c) begin
      state_d  = ST_HUNT;
      seed_d   = '0;
      good_d   = '0;
      loss_d   = '0;
      locked_d = 1'b0;
    end else if (chk_valid) begin
      case (state_q)
        ST_HUNT: begin
          chk_d = seed_s;
          if (SEED_W'(seed_q + SEED_W'(1)) >= seed_words(poly_sel)) begin
            seed_d = '0;
            if (seed_s != '0) state_d = ST_VERIFY;
          end else begin
            seed_d = SEED_W'(seed_q + SEED_W'(1));
          end
        end
        ST_VERIFY: begin
          if (|diff) begin
            state_d = ST_HUNT;
            good_d  = '0;
            seed_d  = '0;
          end else begin
            chk_d = pred_s;
            if (GOOD_W'(good_q + GOOD_W'(1)) == GOOD_W'(LOCK_CNT)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              good_d   = '0;
              loss_d   = '0;
            end else begin
              good_d = GOOD_W'(good_q + GOOD_W'(1));
            end
          end
        end
        ST_LOCKED: begin
          chk_d = pred_s;
          if (|diff) begin
            flag_d = 1'b1;
            err_d  = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : ERR_CNT_W'(err_sum);
            if (LOSS_W'(loss_q + LOSS_W'(1)) == LOSS_W'(LOSS_THR)) begin
              state_d  = ST_HUNT;
              locked_d = 1'b0;
              loss_d   = '0;
              seed_d   = '0;
            end else begin
              loss_d = LOSS_W'(loss_q + LOSS_W'(1));
            end
          end else begin
            loss_d = '0;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    if (clr_cnt) err_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      poly_q   <= poly_sel;
      gen_q    <= LW'(1);
      gdata_q  <= '0;
      gvalid_q <= 1'b0;
      inj_q    <= 1'b0;
      state_q  <= ST_HUNT;
      chk_q    <= '0;
      seed_q   <= '0;
      good_q   <= '0;
      loss_q   <= '0;
      locked_q <= 1'b0;
      flag_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      poly_q   <= poly_sel;
      gen_q    <= gen_d;
      gdata_q  <= gdata_d;
      gvalid_q <= gvalid_d;
      inj_q    <= inj_d;
      state_q  <= state_d;
      chk_q    <= chk_d;
      seed_q   <= seed_d;
      good_q   <= good_d;
      loss_q   <= loss_d;
      locked_q <= locked_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
    end
  end

  assign gen_data  = gdata_q;
  assign gen_valid = gvalid_q;
  assign locked    = locked_q;
  assign err_flag  = flag_q;
  assign err_count = err_q;

endmodule
